lcd_write_scheduler: RTL and testbench

Shares the character-LCD byte-write path between two requesters (ALU core on port 0, secondary source such as an init/debug sequencer on port 1) and sequences each granted byte onto the 4-bit LCD bus as two timed nibble strobes. Sits between the requesters and the LCD pins, and replaces direct wWrite/wData/wReady use of the LCD controller. One byte is in flight at a time. Arbitration is round-robin.

---
 rtl/lcd_write_scheduler_if.sv | 25 ++
 rtl/lcd_write_scheduler.sv | 175 +++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_scheduler_if.sv
// Requester-side handshake bundle for the two ports of the LCD byte-write scheduler.
interface lcd_write_scheduler_if;
  logic       iReq0;
  logic       iRS0;
  logic [7:0] iData0;
  logic       oGnt0;
  logic       iReq1;
  logic       iRS1;
  logic [7:0] iData1;
  logic       oGnt1;

  // Requester side: raises requests, observes grants.
  modport master (
    output iReq0, iRS0, iData0,
    output iReq1, iRS1, iData1,
    input  oGnt0, oGnt1
  );

  // Scheduler side: samples requests, returns grants.
  modport slave (
    input  iReq0, iRS0, iData0,
    input  iReq1, iRS1, iData1,
    output oGnt0, oGnt1
  );
endinterface

// File: rtl/lcd_write_scheduler.sv
// Round-robin arbiter for two byte requesters feeding a 4-bit character-LCD bus.
// Each granted byte is sent as two timed nibble strobes followed by a settle wait.
module lcd_write_scheduler #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 50,
  parameter int unsigned T_BYTE  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  lcd_write_scheduler_if.slave  req,
  output logic                  oBusy,
  output logic                  oLCD_Enabled,
  output logic                  oLCD_RegisterSelect,
  output logic                  oLCD_ReadWrite,
  output logic                  oLCD_StrataFlashControl,
  output logic [3:0]            oLCD_Data
);

  localparam int unsigned CNT_W  = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SETUP_HI = 4'd1,
    S_EN_HI    = 4'd2,
    S_HOLD_HI  = 4'd3,
    S_GAP      = 4'd4,
    S_SETUP_LO = 4'd5,
    S_EN_LO    = 4'd6,
    S_HOLD_LO  = 4'd7,
    S_WAIT     = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                rs_q, rs_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                any_req;
  logic                win1;
  logic                long_wait;

  logic                busy_d;
  logic                en_d;
  logic                rs_out_d;
  logic [NIB_W-1:0]    data_out_d;

  // Phase that follows s once its counter expires.
  function automatic state_t phase_next(input state_t s);
    case (s)
      S_SETUP_HI: phase_next = S_EN_HI;
      S_EN_HI:    phase_next = S_HOLD_HI;
      S_HOLD_HI:  phase_next = S_GAP;
      S_GAP:      phase_next = S_SETUP_LO;
      S_SETUP_LO: phase_next = S_EN_LO;
      S_EN_LO:    phase_next = S_HOLD_LO;
      S_HOLD_LO:  phase_next = S_WAIT;
      default:    phase_next = S_IDLE;
    endcase
  endfunction

  // Counter load value (length - 1) on entry to phase s.
  function automatic logic [CNT_W-1:0] phase_last(input state_t s, input logic long_w);
    case (s)
      S_SETUP_HI, S_SETUP_LO: phase_last = CNT_W'(T_SETUP - 1);
      S_EN_HI, S_EN_LO:       phase_last = CNT_W'(T_EN - 1);
      S_HOLD_HI, S_HOLD_LO:   phase_last = CNT_W'(T_HOLD - 1);
      S_GAP:                  phase_last = CNT_W'(T_GAP - 1);
      S_WAIT:                 phase_last = long_w ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_BYTE - 1);
      default:                phase_last = '0;
    endcase
  endfunction

  // Round-robin decision: port 1 wins when alone or when the pointer favours it.
  assign any_req = req.iReq0 | req.iReq1;
  assign win1    = req.iReq1 & (~req.iReq0 | ptr_q);

  // Clear (0x01) and home (0x02/0x03) commands need the long settle; 0x00 rides along.
  assign long_wait = ~rs_q & (data_q[7:2] == 6'b000000);

  // State, phase counter, pointer and captured byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Next state: grant and capture in IDLE, otherwise count down through the phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          ptr_d   = ~win1;
          rs_d    = win1 ? req.iRS1 : req.iRS0;
          data_d  = win1 ? req.iData1 : req.iData0;
          state_d = S_SETUP_HI;
          cnt_d   = phase_last(S_SETUP_HI, 1'b0);
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = phase_next(state_q);
          cnt_d   = phase_last(phase_next(state_q), long_wait);
        end
      end
    endcase
  end

  // Outputs: grants decode the live IDLE cycle; bus pins are precomputed for the next state.
  always_comb begin
    req.oGnt0  = 1'b0;
    req.oGnt1  = 1'b0;
    busy_d     = 1'b0;
    en_d       = 1'b0;
    rs_out_d   = 1'b0;
    data_out_d = '0;
    if ((state_q == S_IDLE) && Reset && any_req) begin
      req.oGnt1 = win1;
      req.oGnt0 = ~win1;
    end
    busy_d = (state_d != S_IDLE);
    en_d   = (state_d == S_EN_HI) || (state_d == S_EN_LO);
    if (busy_d) begin
      rs_out_d = rs_d;
    end
    case (state_d)
      S_SETUP_HI, S_EN_HI, S_HOLD_HI, S_GAP:     data_out_d = data_d[7:4];
      S_SETUP_LO, S_EN_LO, S_HOLD_LO, S_WAIT:    data_out_d = data_d[3:0];
      default:                                   data_out_d = '0;
    endcase
  end

  // Registered LCD pins and busy flag; reset drops the strobe without waiting for a clock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oBusy               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
    end else begin
      oBusy               <= busy_d;
      oLCD_Enabled        <= en_d;
      oLCD_RegisterSelect <= rs_out_d;
      oLCD_Data           <= data_out_d;
    end
  end

  // Write-only bus with the shared flash device kept disabled.
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for the LCD write scheduler with shortened settle waits.
module tb_lcd_write_scheduler;

  localparam int TB_BYTE  = 200;
  localparam int TB_CLEAR = 820;
  localparam int SP_N     = 281;  // 2+12+1+50+2+12+1+200 + 1 idle cycle
  localparam int SP_C     = 901;  // 2+12+1+50+2+12+1+820 + 1 idle cycle

  logic       clk;
  logic       rst_n;
  logic       busy, en, lrs, rw, sf;
  logic [3:0] ldata;
  int         cyc;
  int         tests_run, tests_failed;

  int         e_rise[$];
  logic [3:0] e_dat[$];
  logic       e_rs[$];
  int         e_wid[$];
  int         g_cyc[$];
  int         g_port[$];
  int         overlap, e_unstable, en_run;
  logic       en_prev;
  logic [3:0] en_dat;

  lcd_write_scheduler_if bus();

  lcd_write_scheduler #(.T_BYTE(TB_BYTE), .T_CLEAR(TB_CLEAR)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .req(bus),
    .oBusy(busy),
    .oLCD_Enabled(en),
    .oLCD_RegisterSelect(lrs),
    .oLCD_ReadWrite(rw),
    .oLCD_StrataFlashControl(sf),
    .oLCD_Data(ldata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe strobes and grants at the falling edge.
  always @(negedge clk) begin
    if (en && !en_prev) begin
      e_rise.push_back(cyc); e_dat.push_back(ldata); e_rs.push_back(lrs); en_dat = ldata;
    end
    if (en && en_prev && ldata != en_dat) e_unstable++;
    if (en) en_run++;
    else if (en_run != 0) begin e_wid.push_back(en_run); en_run = 0; end
    en_prev = en;
    if (bus.oGnt0) begin g_cyc.push_back(cyc); g_port.push_back(0); end
    if (bus.oGnt1) begin g_cyc.push_back(cyc); g_port.push_back(1); end
    if (bus.oGnt0 && bus.oGnt1) overlap++;
  end

  task automatic clear_obs();
    e_rise.delete(); e_dat.delete(); e_rs.delete(); e_wid.delete();
    g_cyc.delete(); g_port.delete(); overlap = 0; e_unstable = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.iReq0 = 0; bus.iRS0 = 0; bus.iData0 = '0;
    bus.iReq1 = 0; bus.iRS1 = 0; bus.iData1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic wait_gnt(input int port, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((port == 0 && bus.oGnt0) || (port == 1 && bus.oGnt1)) begin at = cyc; break; end
    end
  endtask

  task automatic wait_idle(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.iReq1 = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (en !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %0b want 0", en); end
    tests_run++; if (lrs !== 1'b0) begin tests_failed++; $display("FAIL reset_rs: got %0b want 0", lrs); end
    tests_run++; if (ldata !== 4'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", ldata); end
    tests_run++; if (rw !== 1'b0) begin tests_failed++; $display("FAIL reset_rw: got %0b want 0", rw); end
    tests_run++; if (sf !== 1'b1) begin tests_failed++; $display("FAIL reset_sf: got %0b want 1", sf); end
    tests_run++; if (bus.oGnt1 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt1: got %0b want 0", bus.oGnt1); end
    bus.iReq1 = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int g, t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'h41;
    wait_gnt(0, 5, g);
    @(posedge clk); #1 bus.iReq0 = 0;
    wait_idle(400, t);
    tests_run++; if (g < 0) begin tests_failed++; $display("FAIL single_gnt: got timeout want grant"); end
    tests_run++; if (t - g !== SP_N) begin tests_failed++; $display("FAIL single_busy_len: got %0d want %0d", t - g, SP_N); end
    tests_run++; if (g_cyc.size() !== 1) begin tests_failed++; $display("FAIL single_gnt_count: got %0d want 1", g_cyc.size()); end
    tests_run++; if (e_rise.size() !== 2) begin tests_failed++; $display("FAIL single_strobes: got %0d want 2", e_rise.size()); end
    tests_run++; if (e_rise[0] - g !== 3) begin tests_failed++; $display("FAIL single_e_delay: got %0d want 3", e_rise[0] - g); end
    tests_run++; if (e_rise[1] - e_rise[0] !== 65) begin tests_failed++; $display("FAIL single_e_spacing: got %0d want 65", e_rise[1] - e_rise[0]); end
    tests_run++; if (e_wid[0] !== 12 || e_wid[1] !== 12) begin tests_failed++; $display("FAIL single_e_width: got %0d/%0d want 12/12", e_wid[0], e_wid[1]); end
    tests_run++; if (e_dat[0] !== 4'h4 || e_dat[1] !== 4'h1) begin tests_failed++; $display("FAIL single_nibbles: got %h/%h want 4/1", e_dat[0], e_dat[1]); end
    tests_run++; if (e_rs[0] !== 1'b1 || e_rs[1] !== 1'b1) begin tests_failed++; $display("FAIL single_rs: got %0b/%0b want 1/1", e_rs[0], e_rs[1]); end
    tests_run++; if (e_unstable !== 0) begin tests_failed++; $display("FAIL single_stable: got %0d changes want 0", e_unstable); end
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'h48;
    bus.iReq1 = 1; bus.iRS1 = 1; bus.iData1 = 8'h49;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (g_cyc.size() >= 4) break;
    end
    @(posedge clk); #1 bus.iReq0 = 0; bus.iReq1 = 0;
    wait_idle(400, t);
    tests_run++; if (g_cyc.size() !== 4) begin tests_failed++; $display("FAIL b2b_count: got %0d want 4", g_cyc.size()); end
    tests_run++; if (g_port[0] !== 0 || g_port[1] !== 1 || g_port[2] !== 0 || g_port[3] !== 1)
      begin tests_failed++; $display("FAIL b2b_order: got %0d%0d%0d%0d want 0101", g_port[0], g_port[1], g_port[2], g_port[3]); end
    tests_run++; if (g_cyc[1] - g_cyc[0] !== SP_N) begin tests_failed++; $display("FAIL b2b_space01: got %0d want %0d", g_cyc[1] - g_cyc[0], SP_N); end
    tests_run++; if (g_cyc[3] - g_cyc[2] !== SP_N) begin tests_failed++; $display("FAIL b2b_space23: got %0d want %0d", g_cyc[3] - g_cyc[2], SP_N); end
    tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    tests_run++; if (e_dat[2] !== 4'h4 || e_dat[3] !== 4'h9) begin tests_failed++; $display("FAIL b2b_port1_nibbles: got %h/%h want 4/9", e_dat[2], e_dat[3]); end
    tests_run++; if (e_dat[0] !== 4'h4 || e_dat[1] !== 4'h8) begin tests_failed++; $display("FAIL b2b_port0_nibbles: got %h/%h want 4/8", e_dat[0], e_dat[1]); end
  endtask

  task automatic test_clear();
    int g1, g0, t;
    do_reset();
    bus.iReq1 = 1; bus.iRS1 = 0; bus.iData1 = 8'h01;
    wait_gnt(1, 5, g1);
    @(posedge clk); #1 bus.iReq1 = 0;
    repeat (200) @(posedge clk);
    #1 bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'h55;
    wait_gnt(0, 1200, g0);
    @(posedge clk); #1 bus.iReq0 = 0;
    tests_run++; if (g0 < 0 || g0 - g1 !== SP_C) begin tests_failed++; $display("FAIL clear_spacing: got %0d want %0d", g0 - g1, SP_C); end
    tests_run++; if (g_cyc.size() !== 2) begin tests_failed++; $display("FAIL clear_gnt_count: got %0d want 2", g_cyc.size()); end
    tests_run++; if (e_rs[0] !== 1'b0) begin tests_failed++; $display("FAIL clear_rs: got %0b want 0", e_rs[0]); end
    wait_idle(400, t);
  endtask

  task automatic test_wait_len(input logic rs, input logic [7:0] d, input int want, input string nm);
    int g, t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = rs; bus.iData0 = d;
    wait_gnt(0, 5, g);
    @(posedge clk); #1 bus.iReq0 = 0;
    wait_idle(1200, t);
    tests_run++; if (g < 0 || t < 0 || t - g !== want) begin tests_failed++; $display("FAIL wait_len_%s: got %0d want %0d", nm, t - g, want); end
  endtask

  task automatic test_busy_request();
    int g, g1, t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'h41;
    wait_gnt(0, 5, g);
    @(posedge clk); #1 bus.iReq0 = 0;
    repeat (19) @(posedge clk);
    #1 bus.iReq1 = 1; bus.iRS1 = 0;
    for (int i = 0; i < 240; i++) begin
      @(posedge clk); #1 bus.iData1 = 8'($urandom);
    end
    @(posedge clk); #1 bus.iData1 = 8'h5A;
    wait_gnt(1, 100, g1);
    @(posedge clk); #1 bus.iReq1 = 0;
    wait_idle(400, t);
    tests_run++; if (g1 < 0 || g1 - g !== SP_N) begin tests_failed++; $display("FAIL busy_gnt1_time: got %0d want %0d", g1 - g, SP_N); end
    tests_run++; if (g_cyc.size() !== 2) begin tests_failed++; $display("FAIL busy_gnt_count: got %0d want 2", g_cyc.size()); end
    tests_run++; if (e_dat[0] !== 4'h4 || e_dat[1] !== 4'h1) begin tests_failed++; $display("FAIL busy_nibbles0: got %h/%h want 4/1", e_dat[0], e_dat[1]); end
    tests_run++; if (e_dat[2] !== 4'h5 || e_dat[3] !== 4'hA) begin tests_failed++; $display("FAIL busy_nibbles1: got %h/%h want 5/a", e_dat[2], e_dat[3]); end
    tests_run++; if (e_unstable !== 0) begin tests_failed++; $display("FAIL busy_stable: got %0d changes want 0", e_unstable); end
  endtask

  task automatic test_reset_mid();
    int g, t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'hFF;
    wait_gnt(0, 5, g);
    @(posedge clk); #1 bus.iReq0 = 0;
    bus.iReq1 = 1; bus.iRS1 = 1; bus.iData1 = 8'h33;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en) break;
    end
    tests_run++; if (en !== 1'b1 || ldata !== 4'hF) begin tests_failed++; $display("FAIL mid_pre_e: got e=%0b d=%h want e=1 d=f", en, ldata); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (en !== 1'b0) begin tests_failed++; $display("FAIL mid_e: got %0b want 0", en); end
    tests_run++; if (lrs !== 1'b0 || ldata !== 4'h0) begin tests_failed++; $display("FAIL mid_bus: got rs=%0b d=%h want 0/0", lrs, ldata); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %0b want 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    clear_obs();
    @(negedge clk);
    tests_run++; if (bus.oGnt1 !== 1'b1 || bus.oGnt0 !== 1'b0) begin tests_failed++; $display("FAIL mid_regrant: got g0=%0b g1=%0b want 0/1", bus.oGnt0, bus.oGnt1); end
    @(posedge clk); #1 bus.iReq1 = 0;
    wait_idle(400, t);
    tests_run++; if (e_rise.size() !== 2 || e_dat[0] !== 4'h3 || e_dat[1] !== 4'h3) begin tests_failed++; $display("FAIL mid_after: got n=%0d %h/%h want 2 3/3", e_rise.size(), e_dat[0], e_dat[1]); end
  endtask

  task automatic test_withdrawn();
    int g, t;
    do_reset();
    bus.iReq0 = 1; bus.iRS0 = 1; bus.iData0 = 8'h41;
    wait_gnt(0, 5, g);
    @(posedge clk); #1 bus.iReq0 = 0;
    repeat (29) @(posedge clk);
    #1 bus.iReq0 = 1; bus.iData0 = 8'h77;
    repeat (5) @(posedge clk);
    #1 bus.iReq0 = 0;
    wait_idle(400, t);
    repeat (300) @(negedge clk);
    tests_run++; if (g_cyc.size() !== 1) begin tests_failed++; $display("FAIL withdrawn_gnt: got %0d want 1", g_cyc.size()); end
    tests_run++; if (e_rise.size() !== 2) begin tests_failed++; $display("FAIL withdrawn_strobes: got %0d want 2", e_rise.size()); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL withdrawn_busy: got %0b want 0", busy); end
  endtask

  initial begin
    cyc = 0; tests_run = 0; tests_failed = 0;
    en_run = 0; en_prev = 1'b0; en_dat = '0; overlap = 0; e_unstable = 0;
    rst_n = 1'b0;
    bus.iReq0 = 0; bus.iRS0 = 0; bus.iData0 = '0;
    bus.iReq1 = 0; bus.iRS1 = 0; bus.iData1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_wait_len(1'b0, 8'h03, SP_C, "home03");
    test_wait_len(1'b0, 8'h02, SP_C, "home02");
    test_wait_len(1'b0, 8'h04, SP_N, "cmd04");
    test_wait_len(1'b1, 8'h01, SP_N, "data01");
    test_busy_request();
    test_reset_mid();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
